mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory stage, directly downstream of execute. Takes execute's load/store request
//  (addr, byte_sel, un_sign, store data) and runs one data-bus transaction per request.
//  Steers store byte lanes, and extracts and sign- or zero-extends load data.
//  Stalls the pipeline while busy and returns load results to the register file.
// PARAMETERS
//  TIMEOUT  255  cycles of bus_req_o without bus_ready_i before the access is aborted with bus_err_o
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  mem_re_i       in   1   load request from execute
//  mem_raddr_i    in   32  load byte address
//  mem_we_i       in   1   store request from execute
//  mem_waddr_i    in   32  store byte address
//  mem_wdata_i    in   32  store data (rs2)
//  byte_sel_i     in   2   `SL_NONE=0, `SL_BYTE=1, `SL_HALFWORD=2, `SL_WORD=3
//  un_sign_i      in   1   `SIGNED=0, `UNSIGNED=1 (loads only)
//  rd_waddr_i     in   5   load destination register
//  bus_req_o      out  1   transaction valid
//  bus_we_o       out  1   1=write, 0=read
//  bus_addr_o     out  32  word address ({addr[31:2],2'b00})
//  bus_be_o       out  4   byte enables
//  bus_wdata_o    out  32  lane-steered store data
//  bus_ready_i    in   1   slave accepts/completes the access this cycle
//  bus_rdata_i    in   32  read data, valid when bus_ready_i=1
//  stall_o        out  1   hold upstream stages
//  rd_we_o        out  1   load writeback strobe
//  rd_waddr_o     out  5   writeback register
//  rd_wdata_o     out  32  extended load data
//  misalign_o     out  1   1-cycle pulse: misaligned request dropped
//  bus_err_o      out  1   1-cycle pulse: timeout abort
// BEHAVIOUR
//  Reset: state IDLE; every output 0, counter 0.
//  start = (mem_we_i | mem_re_i) & byte_sel_i!=`SL_NONE & aligned; store wins if both re and we are set.
//  Aligned: byte always; halfword needs addr[0]=0; word needs addr[1:0]=0.
//  FSM IDLE -> BUSY -> RESP -> IDLE:
//   IDLE: on start, latch addr/data/sel/sign/rd, go BUSY; stall_o=start (combinational).
//         Misaligned request: misalign_o=1 next cycle, no bus access, no stall.
//   BUSY: bus_req_o=1, bus signals stable from latched values, stall_o=1, counter++.
//         bus_ready_i=1 -> latch rdata, go RESP. Counter reaches TIMEOUT -> bus_err_o pulse,
//         drop bus_req_o, go IDLE with no writeback.
//   RESP: stall_o=0. For loads: rd_we_o=1 for 1 cycle, unless rd=x0 (rd_we_o=0).
//         Stores write nothing back. Next cycle IDLE; a back-to-back start is accepted only from IDLE.
//  Latency: accept cycle 0, bus_req_o from cycle 1, ready in cycle N>=1, writeback in cycle N+1.
//  Store lanes, a=addr[1:0]:
//   byte:     be = 4'b0001<<a, wdata = {4{d[7:0]}}
//   halfword: be = 4'b0011<<a, wdata = {2{d[15:0]}}
//   word:     be = 4'hF,       wdata = d
//  Load:     shift rdata right by 8*a; take 8/16/32 bits; extend by un_sign; loads drive be as for stores.
//  rst mid-transaction: immediate IDLE, bus_req_o drops asynchronously; the slave must tolerate
//  an abandoned request.
// STRUCTURE
//  defines.v gains:
//   - `SL_* and `SIGNED/`UNSIGNED values
//   - state codes `MA_IDLE=2'd0, `MA_BUSY=2'd1, `MA_RESP=2'd2
//   - `BE_WIDTH 3:0
//  Sub-module mem_align (combinational): byte-enable generation, store lane steering,
//  load extract and extend. The FSM, timeout counter and latches stay in mem_access.
// TESTING
//  1. SB addr 0x1003, d=0x000000A5 -> bus_addr 0x1000, be 4'b1000, wdata 0xA5A5A5A5; no rd_we_o.
//  2. LB signed addr 0x2001, rdata 0x00008000 -> rd_wdata_o 0xFFFFFF80.
//     LBU same inputs -> 0x00000080.
//  3. LH addr 0x2002, rdata 0xBEEF1234, ready after 3 cycles -> stall_o high for 4 cycles,
//     rd_wdata_o 0xFFFFBEEF.
//  4. LW addr 0x2002 -> misalign_o pulse, bus_req_o stays 0, stall_o stays 0.
//  5. Load with bus_ready_i held 0 -> bus_err_o pulse after 255 req cycles, IDLE, rd_we_o stays 0.
//  6. rst asserted while BUSY -> bus_req_o and stall_o 0 without a clock edge.
//     LW to x0 afterwards -> bus read occurs, rd_we_o=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage.
//  - byte_sel codes (none/byte/halfword/word) and load sign selection
//  - FSM state type for mem_access
//  - alignment check used to qualify a request before it is accepted
package mem_access_pkg;

    // Access width selection, as driven by execute on byte_sel_i.
    localparam logic [1:0] SlNone     = 2'd0;
    localparam logic [1:0] SlByte     = 2'd1;
    localparam logic [1:0] SlHalfword = 2'd2;
    localparam logic [1:0] SlWord     = 2'd3;

    // Load extension selection, as driven by execute on un_sign_i.
    localparam logic Signed   = 1'b0;
    localparam logic Unsigned = 1'b1;

    localparam int unsigned BeWidth = 4;

    typedef enum logic [1:0] {
        MaIdle = 2'd0,
        MaBusy = 2'd1,
        MaResp = 2'd2
    } ma_state_e;

    // Byte accesses are always aligned; wider accesses must sit on their natural boundary.
    function automatic logic is_aligned(input logic [1:0] sel, input logic [1:0] addr_lo);
        logic ok;
        case (sel)
            SlHalfword: ok = ~addr_lo[0];
            SlWord:     ok = (addr_lo == 2'b00);
            default:    ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic for the memory-access stage.
//  addr_lo_i     byte offset within the word
//  byte_sel_i    access width code
//  un_sign_i     load extension select (0 = sign-extend, 1 = zero-extend)
//  store_data_i  raw store data (rs2)
//  load_data_i   raw word returned by the bus
//  be_o          byte enables for the access (loads and stores alike)
//  wdata_o       store data replicated across all lanes
//  rdata_o       load data shifted down to bit 0 and extended
module mem_access_align
    import mem_access_pkg::*;
(
    input  logic [1:0]         addr_lo_i,
    input  logic [1:0]         byte_sel_i,
    input  logic               un_sign_i,
    input  logic [31:0]        store_data_i,
    input  logic [31:0]        load_data_i,
    output logic [BeWidth-1:0] be_o,
    output logic [31:0]        wdata_o,
    output logic [31:0]        rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        rdata_o = '0;
        shifted = load_data_i >> {addr_lo_i, 3'b000};
        case (byte_sel_i)
            SlByte: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
                rdata_o = (un_sign_i == Unsigned) ? {24'b0, shifted[7:0]}
                                                  : {{24{shifted[7]}}, shifted[7:0]};
            end
            SlHalfword: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{store_data_i[15:0]}};
                rdata_o = (un_sign_i == Unsigned) ? {16'b0, shifted[15:0]}
                                                  : {{16{shifted[15]}}, shifted[15:0]};
            end
            SlWord: begin
                be_o    = 4'hF;
                wdata_o = store_data_i;
                rdata_o = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: turns one load/store request from execute into one data-bus transaction.
//  clk, rst                    clock and asynchronous active-high reset
//  mem_re_i/mem_raddr_i        load request and byte address
//  mem_we_i/mem_waddr_i        store request and byte address (store wins over load)
//  mem_wdata_i                 store data
//  byte_sel_i, un_sign_i       access width and load extension
//  rd_waddr_i                  load destination register
//  bus_*                       single-outstanding data bus (req held until ready)
//  stall_o                     hold upstream stages while a transaction is in flight
//  rd_we_o/rd_waddr_o/rd_wdata_o  load writeback, one cycle after the bus completes
//  misalign_o                  one-cycle pulse: misaligned request dropped
//  bus_err_o                   one-cycle pulse: access aborted after TIMEOUT req cycles
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_re_i,
    input  logic [31:0]        mem_raddr_i,
    input  logic               mem_we_i,
    input  logic [31:0]        mem_waddr_i,
    input  logic [31:0]        mem_wdata_i,
    input  logic [1:0]         byte_sel_i,
    input  logic               un_sign_i,
    input  logic [4:0]         rd_waddr_i,
    output logic               bus_req_o,
    output logic               bus_we_o,
    output logic [31:0]        bus_addr_o,
    output logic [BeWidth-1:0] bus_be_o,
    output logic [31:0]        bus_wdata_o,
    input  logic               bus_ready_i,
    input  logic [31:0]        bus_rdata_i,
    output logic               stall_o,
    output logic               rd_we_o,
    output logic [4:0]         rd_waddr_o,
    output logic [31:0]        rd_wdata_o,
    output logic               misalign_o,
    output logic               bus_err_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    // Last req cycle that may still see ready before the access is abandoned.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    ma_state_e       state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      sel_q, sel_d;
    logic            sign_q, sign_d;
    logic [4:0]      rd_q, rd_d;
    logic            we_q, we_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            misalign_q, misalign_d;
    logic            err_q, err_d;

    logic [31:0]        req_addr;
    logic               req_any;
    logic               req_sized;
    logic               req_aligned;
    logic               start;
    logic               busy;
    logic               resp_load;
    logic [BeWidth-1:0] align_be;
    logic [31:0]        align_wdata;
    logic [31:0]        align_rdata;

    // Request qualification
    assign req_any     = mem_we_i | mem_re_i;
    assign req_addr    = mem_we_i ? mem_waddr_i : mem_raddr_i;
    assign req_sized   = (byte_sel_i != SlNone);
    assign req_aligned = is_aligned(byte_sel_i, req_addr[1:0]);
    assign start       = req_any & req_sized & req_aligned;

    // Next-state and latches
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        sel_d      = sel_q;
        sign_d     = sign_q;
        rd_d       = rd_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        err_d      = 1'b0;
        stall_o    = 1'b0;

        case (state_q)
            MaIdle: begin
                cnt_d = '0;
                // Gated by rst so every output reads 0 while reset is held.
                stall_o = start & ~rst;
                if (start) begin
                    addr_d  = req_addr;
                    wdata_d = mem_wdata_i;
                    sel_d   = byte_sel_i;
                    sign_d  = un_sign_i;
                    rd_d    = rd_waddr_i;
                    we_d    = mem_we_i;
                    state_d = MaBusy;
                end else if (req_any && req_sized) begin
                    misalign_d = 1'b1;
                end
            end
            MaBusy: begin
                stall_o = 1'b1;
                if (bus_ready_i) begin
                    rdata_d = bus_rdata_i;
                    state_d = MaResp;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = MaIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MaResp: begin
                state_d = MaIdle;
            end
            default: begin
                state_d = MaIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MaIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            sel_q      <= SlNone;
            sign_q     <= Signed;
            rd_q       <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            sel_q      <= sel_d;
            sign_q     <= sign_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
        end
    end

    mem_access_align u_align (
        .addr_lo_i    (addr_q[1:0]),
        .byte_sel_i   (sel_q),
        .un_sign_i    (sign_q),
        .store_data_i (wdata_q),
        .load_data_i  (rdata_q),
        .be_o         (align_be),
        .wdata_o      (align_wdata),
        .rdata_o      (align_rdata)
    );

    // Bus side is driven from latched values only while BUSY, so req falls with rst.
    assign busy      = (state_q == MaBusy);
    assign resp_load = (state_q == MaResp) & ~we_q;

    assign bus_req_o   = busy;
    assign bus_we_o    = busy & we_q;
    assign bus_addr_o  = busy ? {addr_q[31:2], 2'b00} : 32'b0;
    assign bus_be_o    = busy ? align_be : '0;
    assign bus_wdata_o = (busy & we_q) ? align_wdata : 32'b0;

    // x0 is hardwired; suppress the strobe but still complete the bus read.
    assign rd_we_o    = resp_load & (rd_q != 5'd0);
    assign rd_waddr_o = resp_load ? rd_q : 5'd0;
    assign rd_wdata_o = resp_load ? align_rdata : 32'b0;

    assign misalign_o = misalign_q;
    assign bus_err_o  = err_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        mem_re_i;
    logic [31:0] mem_raddr_i;
    logic        mem_we_i;
    logic [31:0] mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic [1:0]  byte_sel_i;
    logic        un_sign_i;
    logic [4:0]  rd_waddr_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ready_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o;
    logic        rd_we_o;
    logic [4:0]  rd_waddr_o;
    logic [31:0] rd_wdata_o;
    logic        misalign_o;
    logic        bus_err_o;

    int tests;
    int fails;

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .mem_re_i    (mem_re_i),
        .mem_raddr_i (mem_raddr_i),
        .mem_we_i    (mem_we_i),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
        .byte_sel_i  (byte_sel_i),
        .un_sign_i   (un_sign_i),
        .rd_waddr_i  (rd_waddr_i),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ready_i (bus_ready_i),
        .bus_rdata_i (bus_rdata_i),
        .stall_o     (stall_o),
        .rd_we_o     (rd_we_o),
        .rd_waddr_o  (rd_waddr_o),
        .rd_wdata_o  (rd_wdata_o),
        .misalign_o  (misalign_o),
        .bus_err_o   (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a request at the current time (callers are on a negedge).
    task automatic drive(input logic re, input logic we, input logic [31:0] addr,
                         input logic [31:0] d, input logic [1:0] sel, input logic un,
                         input logic [4:0] rd);
        mem_re_i    = re;
        mem_we_i    = we;
        mem_raddr_i = addr;
        mem_waddr_i = addr;
        mem_wdata_i = d;
        byte_sel_i  = sel;
        un_sign_i   = un;
        rd_waddr_i  = rd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus_ready_i = 1'b0;
        bus_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, stall_o, rd_we_o,
             rd_waddr_o, rd_wdata_o, misalign_o, bus_err_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h stall=%b rdwe=%b",
                     bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, stall_o, rd_we_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // SB to 0x1003: top lane only, data replicated, no writeback.
    task automatic test_store_byte();
        drive(1'b0, 1'b1, 32'h0000_1003, 32'h0000_00A5, 2'd1, 1'b0, 5'd9);
        #1;
        tests++;
        if (stall_o !== 1'b1) begin
            fails++; $display("FAIL sb_accept_stall: got %b want 1", stall_o);
        end
        @(negedge clk);
        idle_inputs();
        tests++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o} !==
            {1'b1, 1'b1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5}) begin
            fails++;
            $display("FAIL sb_bus: got req=%b we=%b addr=%h be=%b wd=%h want 1 1 1000 1000 a5a5a5a5",
                     bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o);
        end
        bus_ready_i = 1'b1;
        @(negedge clk);
        bus_ready_i = 1'b0;
        tests++;
        if ({stall_o, rd_we_o, bus_req_o} !== 3'b000) begin
            fails++;
            $display("FAIL sb_resp: got stall=%b rdwe=%b req=%b want 000", stall_o, rd_we_o,
                     bus_req_o);
        end
        @(negedge clk);
    endtask

    // LB / LBU at 0x2001 with rdata 0x00008000 -> byte 0x80.
    task automatic test_load_byte();
        for (int pass = 0; pass < 2; pass++) begin
            logic [31:0] want;
            want = (pass == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            drive(1'b1, 1'b0, 32'h0000_2001, 32'h0, 2'd1, logic'(pass), 5'd5);
            @(negedge clk);
            idle_inputs();
            tests++;
            if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o} !==
                {1'b1, 1'b0, 32'h0000_2000, 4'b0010}) begin
                fails++;
                $display("FAIL lb_bus[%0d]: got req=%b we=%b addr=%h be=%b", pass, bus_req_o,
                         bus_we_o, bus_addr_o, bus_be_o);
            end
            bus_ready_i = 1'b1;
            bus_rdata_i = 32'h0000_8000;
            @(negedge clk);
            bus_ready_i = 1'b0;
            bus_rdata_i = 32'h0;
            tests++;
            if ({rd_we_o, rd_waddr_o, rd_wdata_o} !== {1'b1, 5'd5, want}) begin
                fails++;
                $display("FAIL lb_wb[%0d]: got we=%b rd=%0d data=%h want 1 5 %h", pass, rd_we_o,
                         rd_waddr_o, rd_wdata_o, want);
            end
            @(negedge clk);
        end
    endtask

    // LH at 0x2002, ready in third req cycle: stall for 4 cycles, writeback in the 5th.
    task automatic test_load_half_latency();
        int stall_cnt;
        stall_cnt = 0;
        drive(1'b1, 1'b0, 32'h0000_2002, 32'h0, 2'd2, 1'b0, 5'd7);
        #1;
        if (stall_o) stall_cnt++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            idle_inputs();
            if (k == 3) begin
                bus_ready_i = 1'b1;
                bus_rdata_i = 32'hBEEF_1234;
            end
            #1;
            if (stall_o) stall_cnt++;
        end
        tests++;
        if (bus_be_o !== 4'b1100) begin
            fails++; $display("FAIL lh_be: got %b want 1100", bus_be_o);
        end
        @(negedge clk);
        bus_ready_i = 1'b0;
        bus_rdata_i = 32'h0;
        if (stall_o) stall_cnt++;
        tests++;
        if (stall_cnt !== 4) begin
            fails++; $display("FAIL lh_stall_cycles: got %0d want 4", stall_cnt);
        end
        tests++;
        if ({rd_we_o, rd_waddr_o, rd_wdata_o} !== {1'b1, 5'd7, 32'hFFFF_BEEF}) begin
            fails++;
            $display("FAIL lh_wb: got we=%b rd=%0d data=%h want 1 7 ffffbeef", rd_we_o,
                     rd_waddr_o, rd_wdata_o);
        end
        @(negedge clk);
    endtask

    // LW at 0x2002 is dropped with a single misalign pulse.
    task automatic test_misalign();
        drive(1'b1, 1'b0, 32'h0000_2002, 32'h0, 2'd3, 1'b0, 5'd4);
        #1;
        tests++;
        if ({stall_o, bus_req_o} !== 2'b00) begin
            fails++; $display("FAIL mis_no_stall: got stall=%b req=%b want 00", stall_o, bus_req_o);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if ({misalign_o, bus_req_o, stall_o} !== 3'b100) begin
            fails++;
            $display("FAIL mis_pulse: got mis=%b req=%b stall=%b want 100", misalign_o,
                     bus_req_o, stall_o);
        end
        @(negedge clk);
        tests++;
        if ({misalign_o, bus_req_o} !== 2'b00) begin
            fails++; $display("FAIL mis_clear: got mis=%b req=%b want 00", misalign_o, bus_req_o);
        end
    endtask

    // Ready never comes: exactly 255 req cycles, then bus_err pulse and no writeback.
    task automatic test_timeout();
        int  req_cnt;
        logic err_seen;
        logic wb_seen;
        req_cnt  = 0;
        err_seen = 1'b0;
        wb_seen  = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_3000, 32'h0, 2'd1, 1'b0, 5'd3);
        for (int c = 0; c < 300 && !err_seen; c++) begin
            @(negedge clk);
            idle_inputs();
            if (bus_req_o) req_cnt++;
            if (rd_we_o) wb_seen = 1'b1;
            if (bus_err_o) err_seen = 1'b1;
        end
        tests++;
        if (err_seen !== 1'b1) begin
            fails++; $display("FAIL to_err: got no bus_err within 300 cycles, want pulse");
        end
        tests++;
        if (req_cnt !== 255) begin
            fails++; $display("FAIL to_req_cycles: got %0d want 255", req_cnt);
        end
        tests++;
        if ({bus_req_o, stall_o, wb_seen} !== 3'b000) begin
            fails++;
            $display("FAIL to_idle: got req=%b stall=%b wb=%b want 000", bus_req_o, stall_o,
                     wb_seen);
        end
        @(negedge clk);
        tests++;
        if ({bus_err_o, rd_we_o} !== 2'b00) begin
            fails++; $display("FAIL to_pulse_end: got err=%b rdwe=%b want 00", bus_err_o, rd_we_o);
        end
    endtask

    // Reset mid-BUSY clears req/stall without a clock edge; then LW to x0 reads but no writeback.
    task automatic test_reset_mid_and_x0();
        drive(1'b1, 1'b0, 32'h0000_3004, 32'h0, 2'd3, 1'b0, 5'd8);
        @(negedge clk);
        idle_inputs();
        tests++;
        if (bus_req_o !== 1'b1) begin
            fails++; $display("FAIL rst_pre_busy: got req=%b want 1", bus_req_o);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus_req_o, stall_o} !== 2'b00) begin
            fails++; $display("FAIL rst_async: got req=%b stall=%b want 00", bus_req_o, stall_o);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_4000, 32'h0, 2'd3, 1'b0, 5'd0);
        @(negedge clk);
        idle_inputs();
        tests++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o} !== {1'b1, 1'b0, 32'h0000_4000, 4'hF})
        begin
            fails++;
            $display("FAIL x0_bus: got req=%b we=%b addr=%h be=%b", bus_req_o, bus_we_o,
                     bus_addr_o, bus_be_o);
        end
        bus_ready_i = 1'b1;
        bus_rdata_i = 32'h1234_5678;
        @(negedge clk);
        bus_ready_i = 1'b0;
        tests++;
        if ({rd_we_o, stall_o} !== 2'b00) begin
            fails++; $display("FAIL x0_no_wb: got rdwe=%b stall=%b want 00", rd_we_o, stall_o);
        end
        @(negedge clk);
    endtask

    // SH with both re and we set (store wins), held request: next start only from IDLE.
    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 32'h0000_1002, 32'h1234_ABCD, 2'd2, 1'b0, 5'd2);
        mem_raddr_i = 32'h0000_9000;
        bus_ready_i = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o} !==
            {1'b1, 1'b1, 32'h0000_1000, 4'b1100, 32'hABCD_ABCD}) begin
            fails++;
            $display("FAIL b2b_sh_bus: got req=%b we=%b addr=%h be=%b wd=%h", bus_req_o,
                     bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o);
        end
        @(negedge clk);
        tests++;
        if ({bus_req_o, stall_o, rd_we_o} !== 3'b000) begin
            fails++;
            $display("FAIL b2b_resp: got req=%b stall=%b rdwe=%b want 000", bus_req_o, stall_o,
                     rd_we_o);
        end
        @(negedge clk);
        tests++;
        if ({bus_req_o, stall_o} !== 2'b01) begin
            fails++; $display("FAIL b2b_idle_accept: got req=%b stall=%b want 01", bus_req_o,
                              stall_o);
        end
        @(negedge clk);
        idle_inputs();
        tests++;
        if (bus_req_o !== 1'b1) begin
            fails++; $display("FAIL b2b_second_req: got %b want 1", bus_req_o);
        end
        @(negedge clk);
        bus_ready_i = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus_req_o, stall_o} !== 2'b00) begin
            fails++; $display("FAIL b2b_drain: got req=%b stall=%b want 00", bus_req_o, stall_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_store_byte();
        test_load_byte();
        test_load_half_latency();
        test_misalign();
        test_timeout();
        test_reset_mid_and_x0();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
